// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, single FSM, valid/ready holding register, overrun pulse.
// Optional UART_RX_MAJORITY_EN: each mid-bit decision is a 2-of-3 vote over three consecutive rxs samples.
module uart_rx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  logic                 r_sync1, r_sync2;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err, r_stop_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_perr_o, r_serr_o, r_overrun, r_busy;

  logic w_rxs, w_sample, w_tick, w_xor, w_par_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_data_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rxs = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  // Decision moves one cycle later so the vote covers mid-1, mid and mid+1.
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2);
  logic [1:0] r_hist;
  always_ff @(posedge clk) begin
    if (reset) r_hist <= 2'b11;
    else       r_hist <= {r_hist[0], w_rxs};
  end
  assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  assign w_sample = w_rxs;
`endif

  assign w_tick    = (r_cnt == BIT_LAST);
  assign w_xor     = (^r_shift) ^ w_sample;
  assign w_par_err = (PARITY_MODE == 2) ? ~w_xor : w_xor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr_o   <= 1'b0;
      r_serr_o   <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && rx_ready) r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == START_LAST) begin
            r_cnt <= '0;
            if (w_sample) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) begin
            r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
            if (r_bitcnt == DATA_LAST) begin
              r_bitcnt <= '0;
              r_state  <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) begin
            r_par_err <= w_par_err;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) begin
            if (r_bitcnt == STOP_LAST) begin
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_bitcnt <= '0;
              // A word being accepted this same cycle frees the holding register.
              if (!r_valid || rx_ready) begin
                r_data   <= r_shift;
                r_perr_o <= r_par_err;
                r_serr_o <= r_stop_err | ~w_sample;
                r_valid  <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_bitcnt   <= r_bitcnt + 1'b1;
              r_stop_err <= r_stop_err | ~w_sample;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign parity_error  = r_perr_o;
  assign stop_error    = r_serr_o;
  assign overrun_error = r_overrun;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: even-parity, odd-parity and 7-bit/2-stop instances on a shared clock.
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic       rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic       val0, val1, val2, pe0, pe1, pe2, se0, se1, se2, ov0, ov1, ov2, bz0, bz1, bz2;

  uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .rx_data_in(rx0), .rx_data(data0), .rx_valid(val0), .rx_ready(rdy0),
    .parity_error(pe0), .stop_error(se0), .overrun_error(ov0), .busy(bz0));
  uart_rx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .rx_data_in(rx1), .rx_data(data1), .rx_valid(val1), .rx_ready(rdy1),
    .parity_error(pe1), .stop_error(se1), .overrun_error(ov1), .busy(bz1));
  uart_rx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(16), .PARITY_MODE(0), .STOP_BITS(2)) u_d7s2 (
    .clk(clk), .reset(reset), .rx_data_in(rx2), .rx_data(data2), .rx_valid(val2), .rx_ready(rdy2),
    .parity_error(pe2), .stop_error(se2), .overrun_error(ov2), .busy(bz2));

  int n_chk = 0;
  int n_err = 0;
  int ovr_cnt0 = 0;
  always @(posedge clk) if (ov0 === 1'b1) ovr_cnt0 = ovr_cnt0 + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic v);
    case (u)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic hold_bit(input int u, input logic v);
    drive(u, v);
    repeat (16) @(negedge clk);
  endtask

  // Frame: start, nb data bits LSB first, optional parity, ns stop bits (sb[0] first); line left high.
  task automatic send(input int u, input logic [8:0] d, input int nb, input int np, input logic pb,
                      input int ns, input logic [1:0] sb);
    hold_bit(u, 1'b0);
    for (int i = 0; i < nb; i++) hold_bit(u, d[i]);
    if (np != 0) hold_bit(u, pb);
    for (int i = 0; i < ns; i++) hold_bit(u, sb[i]);
    drive(u, 1'b1);
  endtask

  initial begin
    bit saw_valid;
    int ovr_base;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_data", 16'(data0), 16'h0);
    chk("reset_valid", 16'(val0), 16'h0);
    chk("reset_busy", 16'(bz0), 16'h0);
    chk("reset_errs", 16'({pe0, se0, ov0}), 16'h0);

    // Even parity, clean frame
    send(0, 9'h0A5, 8, 1, 1'b0, 1, 2'b01);
    chk("even_data", 16'(data0), 16'h00A5);
    chk("even_valid", 16'(val0), 16'h1);
    chk("even_perr", 16'(pe0), 16'h0);
    chk("even_serr", 16'(se0), 16'h0);
    chk("even_busy", 16'(bz0), 16'h0);
    rdy0 = 1'b1;
    @(negedge clk);
    chk("accept_clear", 16'(val0), 16'h0);
    rdy0 = 1'b0;

    // Even parity, bad parity bit
    send(0, 9'h0A5, 8, 1, 1'b1, 1, 2'b01);
    chk("badpar_data", 16'(data0), 16'h00A5);
    chk("badpar_perr", 16'(pe0), 16'h1);
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0;

    // Odd parity: bit 1 is good, bit 0 is bad
    send(1, 9'h0A5, 8, 1, 1'b1, 1, 2'b01);
    chk("odd_valid", 16'(val1), 16'h1);
    chk("odd_perr_ok", 16'(pe1), 16'h0);
    rdy1 = 1'b1; @(negedge clk); rdy1 = 1'b0;
    send(1, 9'h0A5, 8, 1, 1'b0, 1, 2'b01);
    chk("odd_perr_bad", 16'(pe1), 16'h1);
    rdy1 = 1'b1; @(negedge clk); rdy1 = 1'b0;

    // Low stop bit, then false start rejection, then a clean frame
    send(0, 9'h03C, 8, 1, 1'b0, 1, 2'b00);
    chk("stoplow_data", 16'(data0), 16'h003C);
    chk("stoplow_serr", 16'(se0), 16'h1);
    chk("stoplow_perr", 16'(pe0), 16'h0);
    rdy0 = 1'b1;
    repeat (32) @(negedge clk);
    chk("stoplow_idle_valid", 16'(val0), 16'h0);
    chk("stoplow_idle_busy", 16'(bz0), 16'h0);
    rdy0 = 1'b0;
    send(0, 9'h05A, 8, 1, 1'b0, 1, 2'b01);
    chk("after_data", 16'(data0), 16'h005A);
    chk("after_serr", 16'(se0), 16'h0);
    chk("after_perr", 16'(pe0), 16'h0);
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0;

    // 4-cycle glitch on idle line
    saw_valid = 1'b0;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (val0) saw_valid = 1'b1;
    end
    chk("glitch_valid", 16'(saw_valid), 16'h0);
    chk("glitch_busy", 16'(bz0), 16'h0);

    // Overrun: second frame dropped while first is held
    ovr_base = ovr_cnt0;
    send(0, 9'h011, 8, 1, 1'b0, 1, 2'b01);
    chk("ovr_first", 16'(data0), 16'h0011);
    chk("ovr_none_yet", 16'(ovr_cnt0 - ovr_base), 16'h0);
    send(0, 9'h022, 8, 1, 1'b0, 1, 2'b01);
    repeat (4) @(negedge clk);
    chk("ovr_pulses", 16'(ovr_cnt0 - ovr_base), 16'h1);
    chk("ovr_kept_data", 16'(data0), 16'h0011);
    chk("ovr_kept_valid", 16'(val0), 16'h1);
    rdy0 = 1'b1;
    @(negedge clk);
    chk("ovr_accept", 16'(val0), 16'h0);
    rdy0 = 1'b0;

    // 7 data bits, 2 stop bits: second stop low
    send(2, 9'h055, 7, 0, 1'b0, 2, 2'b01);
    chk("d7_data", 16'(data2), 16'h0055);
    chk("d7_serr", 16'(se2), 16'h1);
    chk("d7_perr", 16'(pe2), 16'h0);
    rdy2 = 1'b1;
    repeat (32) @(negedge clk);
    chk("d7_idle", 16'({val2, bz2}), 16'h0);
    rdy2 = 1'b0;

    // Reset during data bit 3
    hold_bit(2, 1'b0);
    hold_bit(2, 1'b1);
    hold_bit(2, 1'b0);
    hold_bit(2, 1'b1);
    rx2 = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy_before", 16'(bz2), 16'h1);
    reset = 1'b1;
    rx2 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 16'(bz2), 16'h0);
    chk("midrst_data", 16'(data2), 16'h0);
    saw_valid = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (val2 || se2 || ov2) saw_valid = 1'b1;
    end
    chk("midrst_no_output", 16'(saw_valid), 16'h0);
    send(2, 9'h07F, 7, 0, 1'b0, 2, 2'b11);
    chk("d7_7f_data", 16'(data2), 16'h007F);
    chk("d7_7f_valid", 16'(val2), 16'h1);
    chk("d7_7f_serr", 16'(se2), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver. Single-FSM design with an internal bit-timing counter, configurable data width, parity mode and stop-bit count. Adds false-start rejection, a valid/ready output holding register and overrun detection. Sits between the serial pin and the parallel consumer (register bank or FIFO).

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first.
CLKS_PER_BIT, 16, clk cycles per bit period, even, >= 4.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2 stop bits checked.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data_in  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received word, stable while rx_valid
rx_valid  output  1  word available, held until accepted
rx_ready  input  1  consumer accepts word when rx_valid && rx_ready
parity_error  output  1  parity mismatch for word in rx_data, qualified by rx_valid
stop_error  output  1  any checked stop bit sampled low, qualified by rx_valid
overrun_error  output  1  one-cycle pulse: frame completed while holding register full, frame dropped
busy  output  1  high in every FSM state except IDLE

Behaviour:
- Reset (synchronous, active-high; clk only): FSM to IDLE, counters to 0, synchroniser flops to 1. rx_data = 0; rx_valid, parity_error, stop_error, overrun_error and busy = 0.
- rx_data_in passes through a 2-flop synchroniser. All sampling uses the synchronised value rxs.
- IDLE: on rxs == 0 go to START and clear the bit counter.
- START: wait CLKS_PER_BIT/2 - 1 cycles, then sample (mid-bit).
  - Sample 1: false start, return to IDLE, no outputs change.
  - Sample 0: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles; shift LSB first. After DATA_BITS samples go to PARITY, or to STOP if PARITY_MODE == 0.
- PARITY: one sample.
  - Even mode: error if XOR(data, bit) != 0.
  - Odd mode: error if XOR(data, bit) != 1.
- STOP: STOP_BITS samples, each CLKS_PER_BIT apart. Any low sample sets stop_error for the frame. Receiver never waits for the line to return high.
- Completion: on the cycle after the last stop sample, FSM returns to IDLE.
  - If rx_valid == 0, or rx_valid && rx_ready on that same cycle: load rx_data, parity_error and stop_error; set rx_valid = 1.
  - Otherwise: keep the old word and flags, pulse overrun_error for 1 cycle, discard the new frame.
- rx_valid clears on the cycle after rx_valid && rx_ready, unless a new load happens in that cycle.
- A frame with errors is still delivered; the flags describe that word only.
- Back-to-back frames: IDLE accepts a new start edge on the cycle it is entered.
- If the last stop bit is low, IDLE sees rxs == 0 immediately, treats it as a start, and START validation applies.
- Latency: a falling edge on rx_data_in reaches rxs after 2 cycles. rx_valid rises (2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1) cycles after the edge, where P = 1 if parity is enabled, else 0.
- Reset mid-frame: the frame is abandoned; no rx_valid and no error pulse for it.
- Arithmetic: bit counter is clog2(DATA_BITS+1) wide; cycle counter is clog2(CLKS_PER_BIT) wide and wraps at CLKS_PER_BIT-1.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each mid-bit sample (start, data, parity, stop) is the 2-of-3 majority of rxs at the mid-1, mid and mid+1 cycles. The decision is still taken at the mid+1 cycle, so total latency is +1 cycle.
- Undefined: single sample at mid-bit; no extra latency or logic.

Test Plan:
- Defaults with PARITY_MODE=1, CLKS_PER_BIT=16: send 0xA5, even parity bit 0, stop 1 -> rx_data=0xA5, rx_valid=1, parity_error=0, stop_error=0; rx_valid clears one cycle after rx_ready.
- Same frame with parity bit inverted -> rx_data=0xA5, parity_error=1. With PARITY_MODE=2 and parity bit 1 -> parity_error=0.
- Stop bit driven low for its full period -> rx_data=0x3C delivered with stop_error=1; the next valid frame 0x5A is received cleanly.
- Low glitch of 4 cycles on an idle line -> busy returns to 0, rx_valid never asserts.
- Two frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun_error pulses once. Then rx_ready=1 -> 0x11 accepted, rx_valid=0.
- DATA_BITS=7, STOP_BITS=2: second stop bit low -> stop_error=1. Separately, reset asserted during bit 3 -> outputs 0, busy=0, no rx_valid for that frame; next frame 0x7F received correctly.
